// File: rtl/bus_master_port_if.sv
// Serial bus signals between one master port and the arbiter/slave side of the
// 2-master/3-slave bus.
interface bus_master_port_if;
  logic bus_request;
  logic bus_address_valid;
  logic bus_grant;
  logic bus_address;
  logic bus_data;
  logic bus_valid;
  logic bus_write_en;
  logic bus_ready;
  logic bus_data_in;
  logic bus_valid_in;

  modport master (
    output bus_request, bus_address_valid, bus_address, bus_data, bus_valid, bus_write_en,
    input  bus_grant, bus_ready, bus_data_in, bus_valid_in
  );

  modport slave (
    input  bus_request, bus_address_valid, bus_address, bus_data, bus_valid, bus_write_en,
    output bus_grant, bus_ready, bus_data_in, bus_valid_in
  );
endinterface

// File: rtl/bus_master_port.sv
// Master-side transaction sequencer: serialises slave select, address and write data
// MSB-first and deserialises read data. Define BUS_MASTER_TIMEOUT_EN for the wait timeout.
module bus_master_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              txn_start,
  input  logic              txn_write,
  input  logic [1:0]        txn_slave,
  input  logic [ADDR_W-1:0] txn_addr,
  input  logic [DATA_W-1:0] txn_wdata,
  output logic              txn_busy,
  output logic              txn_done,
  output logic              txn_error,
  output logic [DATA_W-1:0] txn_rdata,
  bus_master_port_if.master bif
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, REQ, SEL, WAIT_READY, ADDR, WDATA, RDATA, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              write_q, write_d;
  logic [1:0]        slave_q, slave_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_shift_q, rd_shift_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              error_q, error_d;

  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] wdata_sh;
  logic bus_request, bus_address_valid, bus_address, bus_data, bus_valid, bus_write_en;

  // Originals stay latched so a restart after grant loss can resend everything.
  assign addr_sh  = addr_q << bit_cnt_q;
  assign wdata_sh = wdata_q << bit_cnt_q;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d           = state_q;
    bit_cnt_d         = bit_cnt_q;
    write_d           = write_q;
    slave_d           = slave_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    rd_shift_d        = rd_shift_q;
    rdata_d           = rdata_q;
    error_d           = 1'b0;
    bus_request       = 1'b0;
    bus_address_valid = 1'b0;
    bus_address       = 1'b0;
    bus_data          = 1'b0;
    bus_valid         = 1'b0;
    bus_write_en      = 1'b0;
    txn_done          = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
    tmo_cnt_d         = '0;
`endif
    case (state_q)
      IDLE: begin
        if (txn_start) begin
          write_d   = txn_write;
          slave_d   = txn_slave;
          addr_d    = txn_addr;
          wdata_d   = txn_wdata;
          bit_cnt_d = '0;
          if (txn_slave == 2'd3) error_d = 1'b1;
          else                   state_d = REQ;
        end
      end
      REQ: begin
        bus_request       = 1'b1;
        bus_address_valid = 1'b1;
        if (bif.bus_grant) begin
          state_d   = SEL;
          bit_cnt_d = '0;
        end
      end
      SEL: begin
        bus_request = 1'b1;
        bus_valid   = 1'b1;
        bus_address = bit_cnt_q[0] ? slave_q[0] : slave_q[1];
        if (bit_cnt_q == SEL_LAST) begin
          state_d   = WAIT_READY;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      WAIT_READY: begin
        bus_request = 1'b1;
        if (bif.bus_ready) begin
          state_d   = ADDR;
          bit_cnt_d = '0;
        end
      end
      ADDR: begin
        bus_request  = 1'b1;
        bus_valid    = 1'b1;
        bus_write_en = write_q;
        bus_address  = addr_sh[ADDR_W-1];
        if (bit_cnt_q == ADDR_LAST) begin
          state_d   = write_q ? WDATA : RDATA;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      WDATA: begin
        bus_request  = 1'b1;
        bus_valid    = 1'b1;
        bus_write_en = 1'b1;
        bus_data     = wdata_sh[DATA_W-1];
        if (bit_cnt_q == DATA_LAST) begin
          state_d   = DONE;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      RDATA: begin
        bus_request = 1'b1;
        if (bif.bus_valid_in) begin
          rd_shift_d = {rd_shift_q[DATA_W-2:0], bif.bus_data_in};
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = DONE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        txn_done = 1'b1;
        if (!write_q) rdata_d = rd_shift_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Grant loss overrides whatever the state decided, including a final bit.
    if (!bif.bus_grant && (state_q inside {SEL, WAIT_READY, ADDR, WDATA, RDATA})) begin
      state_d    = REQ;
      bit_cnt_d  = '0;
      rd_shift_d = '0;
    end

`ifdef BUS_MASTER_TIMEOUT_EN
    if ((state_q == WAIT_READY || state_q == RDATA) && state_d == state_q) begin
      if (tmo_cnt_q == TMO_LAST) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        error_d   = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      write_q    <= 1'b0;
      slave_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_shift_q <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      write_q    <= write_d;
      slave_q    <= slave_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_shift_q <= rd_shift_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

`ifdef BUS_MASTER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign txn_busy              = (state_q != IDLE);
  assign txn_error             = error_q;
  assign txn_rdata             = rdata_q;
  assign bif.bus_request       = bus_request;
  assign bif.bus_address_valid = bus_address_valid;
  assign bif.bus_address       = bus_address;
  assign bif.bus_data          = bus_data;
  assign bif.bus_valid         = bus_valid;
  assign bif.bus_write_en      = bus_write_en;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: table of directed transactions, reset/timeout sequences,
// then random transactions with random arbiter/slave behaviour against a bus-level model.
module tb_bus_master_port;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 64;
  localparam int BOUND   = 3000;

  logic              clk = 1'b0;
  logic              reset;
  logic              txn_start, txn_write;
  logic [1:0]        txn_slave;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_wdata;
  logic              txn_busy, txn_done, txn_error;
  logic [DATA_W-1:0] txn_rdata;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] model_rdata;

  // hold: REQ cycles with grant low; drop_at: address bit index at which grant is
  // pulled once; gap_at: read bit index preceded by one bus_valid_in gap;
  // poke: txn_start held high while busy. exp_lat counts cycles from the start pulse.
  typedef struct {
    logic              wr;
    logic [1:0]        slave;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rword;
    int                hold;
    int                drop_at;
    int                gap_at;
    bit                poke;
    bit                exp_err;
    int                exp_lat;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];
  vec_t r;

  bus_master_port_if bif();

  bus_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .txn_start (txn_start),
    .txn_write (txn_write),
    .txn_slave (txn_slave),
    .txn_addr  (txn_addr),
    .txn_wdata (txn_wdata),
    .txn_busy  (txn_busy),
    .txn_done  (txn_done),
    .txn_error (txn_error),
    .txn_rdata (txn_rdata),
    .bif       (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Acts as arbiter and slave for one transaction, collecting the serial stream of the
  // last uninterrupted attempt and comparing it with the requested fields.
  task automatic applyStimulus(input vec_t v, input bit rnd);
    int cyc = 0;
    int hold = v.hold;
    int n_a = 0;
    int n_d = 0;
    int rd_idx = 0;
    bit dropped = 1'b0;
    bit gapped = 1'b0;
    bit finished = 1'b0;
    logic [ADDR_W+1:0] acc_a = '0;
    logic [DATA_W-1:0] acc_d = '0;
    logic [DATA_W-1:0] rsh = v.rword;

    txn_write = v.wr;
    txn_slave = v.slave;
    txn_addr  = v.addr;
    txn_wdata = v.wdata;
    txn_start = 1'b1;
    bif.bus_grant    = 1'b1;
    bif.bus_ready    = 1'b1;
    bif.bus_valid_in = 1'b0;
    bif.bus_data_in  = 1'b0;
    tick();
    cyc = 1;
    txn_start = 1'b0;

    while (cyc < BOUND) begin
      checkOutput("req_vs_busy", bif.bus_request, txn_busy && !txn_done);
      checkOutput("valid_in_req", bif.bus_valid && bif.bus_address_valid, 1'b0);
      if (txn_done || txn_error) begin
        finished = 1'b1;
        break;
      end
      if (bif.bus_address_valid) begin
        n_a = 0; n_d = 0; rd_idx = 0; acc_a = '0; acc_d = '0; rsh = v.rword;
      end
      if (bif.bus_valid) begin
        checkOutput("write_en", bif.bus_write_en, (n_a < 2) ? 1'b0 : ((n_a < 2 + ADDR_W) ? v.wr : 1'b1));
        if (n_a < 2 + ADDR_W) begin
          acc_a = {acc_a[ADDR_W:0], bif.bus_address};
          n_a++;
        end else begin
          acc_d = {acc_d[DATA_W-2:0], bif.bus_data};
          n_d++;
        end
      end

      txn_addr  = ADDR_W'($urandom);
      txn_wdata = DATA_W'($urandom);
      txn_slave = 2'($urandom);
      txn_write = 1'($urandom);
      txn_start = (v.poke || (rnd && $urandom_range(1) == 1)) && txn_busy;

      if (bif.bus_address_valid) begin
        if (hold > 0) begin
          bif.bus_grant = 1'b0;
          hold--;
        end else begin
          bif.bus_grant = rnd ? 1'($urandom_range(1)) : 1'b1;
        end
      end else if (!dropped && n_a == 3 + v.drop_at) begin
        bif.bus_grant = 1'b0;
        dropped = 1'b1;
      end else begin
        bif.bus_grant = rnd ? ($urandom_range(15) != 0) : 1'b1;
      end
      bif.bus_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;

      bif.bus_valid_in = 1'b0;
      bif.bus_data_in  = 1'($urandom);
      if (!v.wr && n_a == 2 + ADDR_W && bif.bus_request && !bif.bus_valid &&
          !bif.bus_address_valid && rd_idx < DATA_W) begin
        if (rd_idx == v.gap_at && !gapped) begin
          gapped = 1'b1;
        end else if (!(rnd && $urandom_range(3) == 0)) begin
          bif.bus_valid_in = 1'b1;
          bif.bus_data_in  = rsh[DATA_W-1];
          if (bif.bus_grant) begin
            rsh = {rsh[DATA_W-2:0], 1'b0};
            rd_idx++;
          end
        end
      end
      tick();
      cyc++;
    end

    checkOutput("finished", finished, 1'b1);
    checkOutput("error_pulse", txn_error, v.exp_err);
    checkOutput("done_pulse", txn_done, !v.exp_err);
    if (v.exp_lat != 0) checkOutput("latency", cyc, v.exp_lat);
    if (!v.exp_err) begin
      checkOutput("addr_bits_n", n_a, 2 + ADDR_W);
      checkOutput("addr_bits", acc_a, {v.slave, v.addr});
      checkOutput("wdata_bits_n", n_d, v.wr ? DATA_W : 0);
      if (v.wr) checkOutput("wdata_bits", acc_d, v.wdata);
    end else begin
      checkOutput("err_busy", txn_busy, 1'b0);
    end

    txn_start = 1'b0;
    bif.bus_valid_in = 1'b0;
    tick();
    checkOutput("single_pulse", txn_done | txn_error, 1'b0);
    checkOutput("rdata", txn_rdata, v.exp_rdata);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd2, 12'h0A5, 8'h3C, 8'h00, 0, 99, 99, 1'b0, 1'b0, 25, 8'h00};
    vecs[1] = '{1'b0, 2'd0, 12'h001, 8'h00, 8'hA7, 0, 99,  4, 1'b0, 1'b0, 26, 8'hA7};
    vecs[2] = '{1'b1, 2'd1, 12'h123, 8'h5A, 8'h00, 5, 99, 99, 1'b0, 1'b0, 30, 8'hA7};
    vecs[3] = '{1'b0, 2'd1, 12'hFFF, 8'h00, 8'h3C, 0,  6, 99, 1'b0, 1'b0, 36, 8'h3C};
    vecs[4] = '{1'b1, 2'd3, 12'h456, 8'h77, 8'h00, 0, 99, 99, 1'b0, 1'b1,  1, 8'h3C};
    vecs[5] = '{1'b1, 2'd0, 12'h800, 8'hFF, 8'h00, 0, 99, 99, 1'b1, 1'b0, 25, 8'h3C};
    vecs[6] = '{1'b0, 2'd2, 12'h000, 8'h00, 8'h00, 0, 99, 99, 1'b0, 1'b0, 25, 8'h00};
    vecs[7] = '{1'b0, 2'd2, 12'h555, 8'h00, 8'h81, 0, 99, 99, 1'b1, 1'b0, 25, 8'h81};

    reset = 1'b1;
    txn_start = 1'b0; txn_write = 1'b0; txn_slave = '0; txn_addr = '0; txn_wdata = '0;
    bif.bus_grant = 1'b0; bif.bus_ready = 1'b0; bif.bus_data_in = 1'b0; bif.bus_valid_in = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("reset_txn", {txn_busy, txn_done, txn_error}, 3'b000);
    checkOutput("reset_rdata", txn_rdata, 8'h00);
    checkOutput("reset_bus", {bif.bus_request, bif.bus_address_valid, bif.bus_address,
                              bif.bus_data, bif.bus_valid, bif.bus_write_en}, 6'b0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], 1'b0);

    // Reset in the middle of the address phase: everything clears, no pulse.
    txn_write = 1'b1; txn_slave = 2'd1; txn_addr = 12'h3C3; txn_wdata = 8'h99;
    txn_start = 1'b1; bif.bus_grant = 1'b1; bif.bus_ready = 1'b1;
    tick();
    txn_start = 1'b0;
    repeat (6) tick();
    checkOutput("mid_addr_valid", bif.bus_valid, 1'b1);
    reset = 1'b1;
    tick();
    checkOutput("midrst_txn", {txn_busy, txn_done, txn_error}, 3'b000);
    checkOutput("midrst_rdata", txn_rdata, 8'h00);
    checkOutput("midrst_bus", {bif.bus_request, bif.bus_address_valid, bif.bus_address,
                               bif.bus_data, bif.bus_valid, bif.bus_write_en}, 6'b0);
    reset = 1'b0;
    tick();
    checkOutput("midrst_after", {txn_busy, txn_done, txn_error}, 3'b000);
    model_rdata = '0;

`ifdef BUS_MASTER_TIMEOUT_EN
    begin
      int wr_cycles;
      bit seen;
      wr_cycles = 0;
      seen = 1'b0;
      txn_write = 1'b0; txn_slave = 2'd1; txn_addr = 12'h00F;
      txn_start = 1'b1; bif.bus_grant = 1'b1; bif.bus_ready = 1'b0;
      tick();
      txn_start = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        if (txn_error) begin
          seen = 1'b1;
        end else begin
          if (bif.bus_request && !bif.bus_address_valid && !bif.bus_valid) wr_cycles++;
          tick();
        end
      end
      checkOutput("tmo_seen", seen, 1'b1);
      checkOutput("tmo_cycles", wr_cycles, TIMEOUT);
      checkOutput("tmo_idle", {txn_busy, bif.bus_request, txn_done}, 3'b000);
      checkOutput("tmo_rdata", txn_rdata, model_rdata);
      bif.bus_ready = 1'b1;
      tick();
    end
`endif

    for (int i = 0; i < 40; i++) begin
      r.wr      = 1'($urandom);
      r.slave   = 2'($urandom);
      r.addr    = ADDR_W'($urandom);
      r.wdata   = DATA_W'($urandom);
      r.rword   = DATA_W'($urandom);
      r.hold    = 0;
      r.drop_at = 99;
      r.gap_at  = 99;
      r.poke    = 1'b0;
      r.exp_err = (r.slave == 2'd3);
      if (!r.exp_err && !r.wr) model_rdata = r.rword;
      r.exp_rdata = model_rdata;
      r.exp_lat   = 0;
      applyStimulus(r, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side transaction sequencer for the serial 2-master/3-slave bus.
- Accepts one parallel transaction (slave select, memory address, write data or read) from the local core.
- Requests the bus from the arbiter, serialises slave select, address and write data MSB-first on 1-bit lines, and deserialises read data.
- Restarts the transaction if the grant is withdrawn; one instance per master port.

Parameters:
- ADDR_W, 12, memory address bits sent after slave select
- DATA_W, 8, data word bits
- TIMEOUT, 64, cycles allowed in WAIT_READY/RDATA (used only with optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- txn_start  in  1  pulse: launch transaction (honoured in IDLE only)
- txn_write  in  1  1=write, 0=read
- txn_slave  in  2  target slave 0..2 (3 illegal)
- txn_addr  in  ADDR_W  memory address
- txn_wdata  in  DATA_W  write data
- txn_busy  out  1  transaction in progress
- txn_done  out  1  one-cycle completion pulse
- txn_error  out  1  one-cycle abort pulse (illegal slave or timeout)
- txn_rdata  out  DATA_W  last completed read word
- bus_request  out  1  request to arbiter
- bus_address_valid  out  1  slave select about to follow
- bus_grant  in  1  arbiter availability/grant for this master
- bus_address  out  1  serial slave-select/address bit
- bus_data  out  1  serial write-data bit
- bus_valid  out  1  bit on bus_address/bus_data valid
- bus_write_en  out  1  transfer direction
- bus_ready  in  1  connected slave ready
- bus_data_in  in  1  serial read-data bit
- bus_valid_in  in  1  read bit valid

Behaviour:
- Reset: state IDLE; all outputs 0; txn_rdata 0; counters 0. Reset mid-transaction aborts with no done/error pulse.
- IDLE: on txn_start latch all txn_* fields; txn_slave==3 -> txn_error pulse next cycle, stay IDLE; else -> REQ. txn_start outside IDLE ignored.
- txn_busy=1 in every state except IDLE.
- REQ: bus_request=1, bus_address_valid=1; bus_grant=1 -> SEL.
- SEL: 2 cycles, bus_valid=1, bus_address=slave[1] then slave[0] -> WAIT_READY.
- WAIT_READY: bus_valid=0; bus_ready=1 -> ADDR.
- ADDR: ADDR_W cycles, bus_valid=1, bus_address=addr MSB first, bus_write_en=txn_write. After last bit: write -> WDATA, read -> RDATA.
- WDATA: DATA_W cycles, bus_valid=1, bus_data=wdata MSB first, bus_write_en=1 -> DONE.
- RDATA: bus_valid=0; each cycle with bus_valid_in=1 shifts bus_data_in into LSB of shift register; after DATA_W bits -> DONE.
- DONE: bus_request=0; txn_done=1 for one cycle; read updates txn_rdata (held until next completed read) -> IDLE.
- bus_request stays high REQ through RDATA; drops in DONE.
- Grant loss: bus_grant=0 in SEL..RDATA -> REQ next cycle, bit counter cleared, partial read discarded, whole transaction restarts from slave select. Grant loss and final bit in the same cycle: restart wins.
- Bit counter width = clog2(max(ADDR_W, DATA_W)+1).
- Back-to-back: new txn_start accepted in the IDLE cycle following DONE.

Optional Feature:
- BUS_MASTER_TIMEOUT_EN defined: cycle counter runs in WAIT_READY and RDATA and clears on each state entry. Reaching TIMEOUT -> bus_request=0, txn_error pulse, -> IDLE, txn_rdata unchanged.
- Macro undefined: no counter; these states wait indefinitely; txn_error fires only for illegal slave.

Test Plan:
- Write slave=2, addr=0x0A5, data=0x3C, grant and ready immediate -> bus_address bits 1,0 then 000010100101, bus_data 00111100; txn_done 2+1+12+8+1 cycles after REQ.
- Read slave=0, addr=0x001, slave returns 0xA7 with one bus_valid_in gap -> txn_rdata=0xA7, single txn_done pulse, bus_valid=0 during RDATA.
- Grant held low 5 cycles in REQ -> bus_request high throughout, no bus_valid until grant.
- Grant dropped at address bit 6 -> return to REQ; after regrant full slave select and all 12 address bits resent; exactly one txn_done.
- txn_slave=3 -> txn_error one cycle, bus_request never asserted; txn_start while busy ignored.
- With BUS_MASTER_TIMEOUT_EN, TIMEOUT=64, bus_ready held 0 -> txn_error at cycle 64 of WAIT_READY, state IDLE; reset mid-ADDR -> all outputs 0 next cycle.
